// File: rtl/grf_wb_queue_if.sv
// Bundle between the two writeback producers, the GRF write port and decode's
// hazard logic. The slave side is the queue; the master side is everything else.
interface grf_wb_queue_if;
    logic        s0_valid;
    logic        s0_ready;
    logic [4:0]  s0_addr;
    logic [31:0] s0_data;
    logic [31:0] s0_pc;

    logic        s1_valid;
    logic        s1_ready;
    logic [4:0]  s1_addr;
    logic [31:0] s1_data;
    logic [31:0] s1_pc;

    logic        Enabled;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] WPC;
    logic [31:0] pend_mask;
    logic [31:0] wr_count;

    modport master (
        output s0_valid, s0_addr, s0_data, s0_pc,
        output s1_valid, s1_addr, s1_data, s1_pc,
        input  s0_ready, s1_ready,
        input  Enabled, A3, WD3, WPC, pend_mask, wr_count
    );

    modport slave (
        input  s0_valid, s0_addr, s0_data, s0_pc,
        input  s1_valid, s1_addr, s1_data, s1_pc,
        output s0_ready, s1_ready,
        output Enabled, A3, WD3, WPC, pend_mask, wr_count
    );
endinterface

// File: rtl/grf_wb_queue.sv
// In-order writeback queue feeding the GRF write port from the ALU/load path (s0)
// and the mul/div unit (s1); up to two pushes and one registered issue per cycle.
module grf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    grf_wb_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    r_mem_addr [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_enabled;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;
    logic [31:0]   r_wpc;
    logic [31:0]   r_wr_count;

    logic [CW-1:0] w_free;
    logic          w_s0_ready;
    logic          w_s1_ready;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic [AW-1:0] w_wr_ptr1;
    logic [31:0]   w_pend_mask;

    // Free space ignores this cycle's pop, so a full queue refuses both producers.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_s0_ready = (w_free >= CW'(1));
    assign w_push0    = bus.s0_valid && w_s0_ready && (bus.s0_addr != 5'd0);
    assign w_s1_ready = (w_free >= (CW'(1) + CW'(w_push0)));
    assign w_push1    = bus.s1_valid && w_s1_ready && (bus.s1_addr != 5'd0);
    assign w_pop      = (r_count != '0);
    assign w_wr_ptr1  = r_wr_ptr + AW'(w_push0);

    // NOTE: storage array has no reset; only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_mem_addr[r_wr_ptr] <= bus.s0_addr;
            r_mem_data[r_wr_ptr] <= bus.s0_data;
            r_mem_pc[r_wr_ptr]   <= bus.s0_pc;
        end
        if (w_push1) begin
            r_mem_addr[w_wr_ptr1] <= bus.s1_addr;
            r_mem_data[w_wr_ptr1] <= bus.s1_data;
            r_mem_pc[w_wr_ptr1]   <= bus.s1_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_enabled  <= 1'b0;
            r_a3       <= 5'd0;
            r_wd3      <= 32'd0;
            r_wpc      <= 32'd0;
            r_wr_count <= 32'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
            r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
            if (w_pop) begin
                r_enabled  <= 1'b1;
                r_a3       <= r_mem_addr[r_rd_ptr];
                r_wd3      <= r_mem_data[r_rd_ptr];
                r_wpc      <= r_mem_pc[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_enabled <= 1'b0;
            end
        end
    end

    // NOTE: the mask starts from a full default so this block cannot infer latches.
    always_comb begin
        w_pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                w_pend_mask[r_mem_addr[r_rd_ptr + AW'(i)]] = 1'b1;
            end
        end
        if (r_enabled) begin
            w_pend_mask[r_a3] = 1'b1;
        end
        w_pend_mask[0] = 1'b0;
    end

    assign bus.s0_ready  = w_s0_ready;
    assign bus.s1_ready  = w_s1_ready;
    assign bus.Enabled   = r_enabled;
    assign bus.A3        = r_a3;
    assign bus.WD3       = r_wd3;
    assign bus.WPC       = r_wpc;
    assign bus.pend_mask = w_pend_mask;
    assign bus.wr_count  = r_wr_count;
endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based model of the writeback rules.
module tb_grf_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    req_t        m_q[$];
    logic        m_en;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic [31:0] m_wpc;
    logic [31:0] m_cnt;

    grf_wb_queue_if bus ();

    grf_wb_queue #(.DEPTH(DEPTH), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic v, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] p);
        req_t r;
        r.v = v; r.a = a; r.d = d; r.p = p;
        return r;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'd0;
        foreach (m_q[i]) m[m_q[i].a] = 1'b1;
        if (m_en) m[m_a3] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_en = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0; m_wpc = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic drive_idle();
        bus.s0_valid = 1'b0; bus.s0_addr = 5'd0; bus.s0_data = 32'd0; bus.s0_pc = 32'd0;
        bus.s1_valid = 1'b0; bus.s1_addr = 5'd0; bus.s1_data = 32'd0; bus.s1_pc = 32'd0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},   {31'd0, bus.Enabled}, 32'd0);
        check({tag, "_a3"},   {27'd0, bus.A3}, 32'd0);
        check({tag, "_wd3"},  bus.WD3, 32'd0);
        check({tag, "_wpc"},  bus.WPC, 32'd0);
        check({tag, "_pend"}, bus.pend_mask, 32'd0);
        check({tag, "_cnt"},  bus.wr_count, 32'd0);
    endtask

    // One clock: drive at negedge, compare just after, then advance the model at posedge.
    task automatic cycle(input req_t r0, input req_t r1);
        int free;
        bit st0, st1, e0r, e1r;
        req_t h;
        @(negedge clk);
        bus.s0_valid = r0.v; bus.s0_addr = r0.a; bus.s0_data = r0.d; bus.s0_pc = r0.p;
        bus.s1_valid = r1.v; bus.s1_addr = r1.a; bus.s1_data = r1.d; bus.s1_pc = r1.p;
        #1;
        free = DEPTH - m_q.size();
        e0r  = (free >= 1);
        st0  = r0.v && e0r && (r0.a != 5'd0);
        e1r  = (free >= 1 + int'(st0));
        st1  = r1.v && e1r && (r1.a != 5'd0);
        check("s0_ready",  {31'd0, bus.s0_ready}, {31'd0, e0r});
        check("s1_ready",  {31'd0, bus.s1_ready}, {31'd0, e1r});
        check("Enabled",   {31'd0, bus.Enabled}, {31'd0, m_en});
        check("A3",        {27'd0, bus.A3}, {27'd0, m_a3});
        check("WD3",       bus.WD3, m_wd3);
        check("WPC",       bus.WPC, m_wpc);
        check("pend_mask", bus.pend_mask, model_mask());
        check("wr_count",  bus.wr_count, m_cnt);
        @(posedge clk);
        if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_en = 1'b1; m_a3 = h.a; m_wd3 = h.d; m_wpc = h.p; m_cnt = m_cnt + 32'd1;
        end else begin
            m_en = 1'b0;
        end
        if (st0) m_q.push_back(r0);
        if (st1) m_q.push_back(r1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        drive_idle();
        #2 reset = 1'b0;
        #1 check_zero(tag);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.v = ($urandom_range(0, 99) < 60);
        r.a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r.d = $urandom;
        r.p = $urandom;
        return r;
    endfunction

    initial begin
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_zero("in_reset");
        @(negedge clk);
        reset = 1'b1;
        idle(10);

        // Single write to r5
        cycle(mk(1, 5'd5, 32'h1234, 32'h3000), mk(0, 0, 0, 0));
        idle(4);
        check("single_wr_count", bus.wr_count, 32'd1);

        // Same-cycle dual push: s0 issues before s1
        cycle(mk(1, 5'd3, 32'hAAAA_0003, 32'h100), mk(1, 5'd4, 32'hBBBB_0004, 32'h104));
        idle(4);

        // $0 filter alone, then at free==1 alongside a real s1 write
        cycle(mk(1, 5'd0, 32'hFFFF, 32'h200), mk(0, 0, 0, 0));
        idle(3);
        cycle(mk(1, 5'd10, 32'h10, 32'h300), mk(1, 5'd11, 32'h11, 32'h304));
        cycle(mk(1, 5'd12, 32'h12, 32'h308), mk(1, 5'd13, 32'h13, 32'h30C));
        cycle(mk(1, 5'd0,  32'h0,  32'h310), mk(1, 5'd7,  32'h77, 32'h314));
        idle(6);

        // Fill and backpressure: both producers always valid
        for (int k = 0; k < 6; k++)
            cycle(mk(1, 5'(2 * k + 1), 32'(k * 2 + 1000), 32'(k * 8)),
                  mk(1, 5'(2 * k + 2), 32'(k * 2 + 2000), 32'(k * 8 + 4)));
        idle(8);

        // Hazard mask with duplicate destinations
        cycle(mk(1, 5'd9, 32'h9001, 32'h400), mk(1, 5'd9, 32'h9002, 32'h404));
        cycle(mk(1, 5'd2, 32'h2001, 32'h408), mk(0, 0, 0, 0));
        idle(5);

        // Reset in the middle of a burst
        cycle(mk(1, 5'd20, 32'h20, 32'h500), mk(1, 5'd21, 32'h21, 32'h504));
        cycle(mk(1, 5'd22, 32'h22, 32'h508), mk(1, 5'd23, 32'h23, 32'h50C));
        reset_mid("mid_reset");
        idle(3);

        // Random traffic with one more reset partway
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) reset_mid("rand_reset");
            cycle(rnd_req(), rnd_req());
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
